// File: rtl/display_scan_pkg.sv
// display_scan_pkg
// Shared definitions for the multiplexed 4-digit display driver:
//   - anode enable patterns (active-low, one digit lit at a time)
//   - BCD / binary widths and digit count
//   - conversion FSM state type
//   - helpers for anode rotation and the double-dabble adjust step
package display_scan_pkg;

    localparam logic [3:0] DIG0 = 4'b0111;
    localparam logic [3:0] DIG1 = 4'b1011;
    localparam logic [3:0] DIG2 = 4'b1101;
    localparam logic [3:0] DIG3 = 4'b1110;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int SCRATCH_W  = BCD_W * NUM_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    // Next anode pattern in the rotation; anything unexpected recovers to DIG0
    // so only the four legal patterns can ever be produced.
    function automatic logic [3:0] next_anode(input logic [3:0] cur);
        logic [3:0] nxt;
        case (cur)
            DIG0:    nxt = DIG1;
            DIG1:    nxt = DIG2;
            DIG2:    nxt = DIG3;
            DIG3:    nxt = DIG0;
            default: nxt = DIG0;
        endcase
        return nxt;
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more,
    // so the following left shift carries correctly into the next digit.
    function automatic logic [SCRATCH_W-1:0] add3_nibbles(input logic [SCRATCH_W-1:0] s);
        logic [SCRATCH_W-1:0] r;
        logic [BCD_W-1:0]     nib;
        r = s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = s[i*BCD_W +: BCD_W];
            if (nib >= 4'd5) begin
                r[i*BCD_W +: BCD_W] = nib + 4'd3;
            end else begin
                r[i*BCD_W +: BCD_W] = nib;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential shift-and-add-3 binary to BCD converter, one bit per clock.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : load strobe, honoured only when idle
//   bin   : 14-bit binary value (already saturated by the caller)
//   busy  : high from the cycle after start until the result is committed
//   done  : one-cycle pulse when bcd takes its new value
//   bcd   : committed digits, [3:0] thousands .. [15:12] units
module bin2bcd_seq
    import display_scan_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIN_W-1:0]     bin,
    output logic                 busy,
    output logic                 done,
    output logic [SCRATCH_W-1:0] bcd
);

    localparam logic [3:0] LAST_STEP = 4'(BIN_W - 1);

    conv_state_e          state_q,   state_d;
    logic [3:0]           count_q,   count_d;
    logic [BIN_W-1:0]     bin_q,     bin_d;
    logic [SCRATCH_W-1:0] scratch_q, scratch_d;
    logic [SCRATCH_W-1:0] bcd_q,     bcd_d;
    logic                 done_q,    done_d;
    logic                 busy_q,    busy_d;
    logic [SCRATCH_W+BIN_W-1:0] shifted_s;

    // Next-state and datapath for the conversion FSM.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        shifted_s = {add3_nibbles(scratch_q), bin_q} << 1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d     = bin;
                    scratch_d = '0;
                    count_d   = 4'd0;
                    state_d   = ST_SHIFT;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                scratch_d = shifted_s[SCRATCH_W+BIN_W-1:BIN_W];
                bin_d     = shifted_s[BIN_W-1:0];
                if (count_q == LAST_STEP) begin
                    count_d = 4'd0;
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + 4'd1;
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // Scratch holds thousands in the top nibble; the output wants
                // thousands in the bottom nibble, so the digit order is reversed.
                bcd_d   = {scratch_q[3:0], scratch_q[7:4], scratch_q[11:8], scratch_q[15:12]};
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Conversion state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= 4'd0;
            bin_q     <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/display_scan.sv
// display_scan
// Four-digit multiplexed display driver: converts a saturated binary score to
// BCD and continuously rotates the active-low anode enables.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   valor   : 14-bit binary score
//   cargar  : one-cycle load strobe, ignored while a conversion is running
//   ocupado : conversion in progress
//   listo   : one-cycle pulse when bcd is updated
//   bcd     : [3:0] thousands, [7:4] hundreds, [11:8] tens, [15:12] units
//   anodos  : active-low digit enable, exactly one bit low
module display_scan
    import display_scan_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned MAXVAL   = 9999
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BIN_W-1:0]     valor,
    input  logic                 cargar,
    output logic                 ocupado,
    output logic                 listo,
    output logic [SCRATCH_W-1:0] bcd,
    output logic [3:0]           anodos
);

    localparam logic [19:0]      PRE_LAST = 20'(PRESCALE - 1);
    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAXVAL);

    logic [BIN_W-1:0] valor_sat_s;
    logic [19:0]      cnt_q,    cnt_d;
    logic [3:0]       anodos_q, anodos_d;

    // Clamp the incoming score to the display ceiling.
    always_comb begin
        if (valor > MAX_BIN) begin
            valor_sat_s = MAX_BIN;
        end else begin
            valor_sat_s = valor;
        end
    end

    // Free-running prescaler; anodes advance on each wrap.
    always_comb begin
        if (cnt_q == PRE_LAST) begin
            cnt_d    = 20'd0;
            anodos_d = next_anode(anodos_q);
        end else begin
            cnt_d    = cnt_q + 20'd1;
            anodos_d = anodos_q;
        end
    end

    // Scan counter and anode register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 20'd0;
            anodos_q <= DIG0;
        end else begin
            cnt_q    <= cnt_d;
            anodos_q <= anodos_d;
        end
    end

    assign anodos = anodos_q;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (cargar),
        .bin   (valor_sat_s),
        .busy  (ocupado),
        .done  (listo),
        .bcd   (bcd)
    );

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan
// Scoreboard bench for display_scan: loads push expected (value, edge) pairs,
// a negedge monitor checks listo/bcd/ocupado/anodos against a reference model.
module tb_display_scan;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cargar = 1'b0;
    logic [13:0] valor = 14'd0;
    logic        ocupado;
    logic        listo;
    logic [15:0] bcd;
    logic [3:0]  anodos;

    display_scan #(.PRESCALE(P), .MAXVAL(9999)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valor   (valor),
        .cargar  (cargar),
        .ocupado (ocupado),
        .listo   (listo),
        .bcd     (bcd),
        .anodos  (anodos)
    );

    always #5 clk = ~clk;

    // Rising edges seen since reset release.
    int edges;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    typedef struct {
        logic [15:0] val;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          last_acc = -1000;
    logic [15:0] cur_bcd = 16'h0000;
    logic [3:0]  pats[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edges);
        end
    endtask

    // Decimal digits of the saturated value, thousands in the low nibble.
    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s % 10), 4'((s / 10) % 10), 4'((s / 100) % 10), 4'(s / 1000)};
    endfunction

    task automatic load(input int v);
        @(negedge clk);
        #1;
        valor  = 14'(v);
        cargar = 1'b1;
        @(posedge clk);
        #1;
        // A load is taken only once the previous one has fully finished.
        if (edges >= last_acc + 16) begin
            last_acc = edges;
            sb.push_back('{ref_bcd(v), edges + 15});
        end
        @(negedge clk);
        cargar = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        last_acc = -1000;
        cur_bcd  = 16'h0000;
        #1;
        check("rst_ocupado", ocupado, 0);
        check("rst_listo", listo, 0);
        check("rst_bcd", bcd, 0);
        check("rst_anodos", anodos, 4'b0111);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every cycle against the model.
    always @(negedge clk) begin
        if (sb.size() > 0 && edges == sb[0].at) begin
            check("listo", listo, 1);
            check("bcd_commit", bcd, sb[0].val);
            cur_bcd = sb[0].val;
            void'(sb.pop_front());
        end else if (listo) begin
            check("listo_spurious", listo, 0);
        end
        check("bcd_hold", bcd, cur_bcd);
        check("ocupado", ocupado, (edges >= last_acc && edges <= last_acc + 14) ? 1 : 0);
        check("anodos", anodos, pats[(edges / P) % 4]);
    end

    initial begin
        do_reset();
        repeat (20) @(negedge clk);
        load(1234);
        repeat (20) @(negedge clk);
        load(12000);
        repeat (18) @(negedge clk);
        load(0);
        repeat (18) @(negedge clk);
        load(16383);
        repeat (18) @(negedge clk);
        load(5);
        repeat (3) @(negedge clk);
        load(77);
        repeat (20) @(negedge clk);
        load(4321);
        repeat (7) @(negedge clk);
        do_reset();
        repeat (30) @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) load(int'($urandom_range(9999, 16383)));
            else                           load(int'($urandom_range(0, 9999)));
            repeat ($urandom_range(0, 18)) @(negedge clk);
        end
        for (int w = 0; w < 40 && sb.size() > 0; w++) @(negedge clk);
        check("drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
